// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-level interrupt controller with per-source gateway,
// priority arbitration, claim/complete register port and prescaled mtime.
module irq_ctrl #(
    parameter int unsigned NUM_SRC  = 8,
    parameter int unsigned PRIO_W   = 3,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               reg_re,
    input  logic               reg_we,
    input  logic [7:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               ext_int,
    output logic               timer_int
);

    localparam int unsigned ID_W = 5;
    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [7:0] ADDR_ENABLE    = 8'h00;
    localparam logic [7:0] ADDR_PENDING   = 8'h04;
    localparam logic [7:0] ADDR_THRESHOLD = 8'h08;
    localparam logic [7:0] ADDR_CLAIM     = 8'h0C;
    localparam logic [7:0] ADDR_MTIME     = 8'h10;
    localparam logic [7:0] ADDR_MTIMECMP  = 8'h14;
    localparam logic [7:0] ADDR_PRIO_BASE = 8'h40;

    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [PRIO_W-1:0]  threshold;
    logic [PRIO_W-1:0]  prio [NUM_SRC];
    logic [31:0]        mtime;
    logic [31:0]        mtimecmp;
    logic [PS_W-1:0]    prescaler;

    logic [ID_W-1:0]    best_id;
    logic [PRIO_W-1:0]  best_prio;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] complete_mask;
    logic [5:0]         prio_idx;
    logic               prio_hit;
    logic [31:0]        rd_val;
    logic               tick;

    // Highest priority eligible source; scanning upward with a strict
    // compare keeps the lowest ID on ties.
    always_comb begin
        best_id   = '0;
        best_prio = threshold;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && enable[i] && (prio[i] > best_prio)) begin
                best_id   = ID_W'(i + 1);
                best_prio = prio[i];
            end
        end
    end

    // Claim/complete masks and PRIO window decode.
    always_comb begin
        claim_mask    = '0;
        complete_mask = '0;
        if (reg_re && (reg_addr == ADDR_CLAIM) && (best_id != '0)) begin
            claim_mask = NUM_SRC'(1) << (best_id - ID_W'(1));
        end
        if (reg_we && (reg_addr == ADDR_CLAIM) && (reg_wdata != 32'd0) &&
            (reg_wdata <= 32'(NUM_SRC))) begin
            complete_mask = NUM_SRC'(1) << (reg_wdata[ID_W-1:0] - ID_W'(1));
        end
        prio_idx = reg_addr[7:2] - 6'h10;
        prio_hit = (reg_addr >= ADDR_PRIO_BASE) && (reg_addr[1:0] == 2'b00) &&
                   (prio_idx < 6'(NUM_SRC));
        tick     = (prescaler == PS_W'(TICK_DIV - 1));
    end

    // Read mux; values reflect state before any same-cycle write.
    always_comb begin
        rd_val = '0;
        case (reg_addr)
            ADDR_ENABLE:    rd_val = 32'(enable);
            ADDR_PENDING:   rd_val = 32'(pending);
            ADDR_THRESHOLD: rd_val = 32'(threshold);
            ADDR_CLAIM:     rd_val = 32'(best_id);
            ADDR_MTIME:     rd_val = mtime;
            ADDR_MTIMECMP:  rd_val = mtimecmp;
            default: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (prio_hit && (prio_idx == 6'(i))) begin
                        rd_val = 32'(prio[i]);
                    end
                end
            end
        endcase
    end

    // State registers: gateway, config, timer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable     <= '0;
            pending    <= '0;
            in_service <= '0;
            threshold  <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio[i] <= '0;
            end
            mtime      <= '0;
            mtimecmp   <= 32'hFFFF_FFFF;
            prescaler  <= '0;
            reg_rdata  <= '0;
            ext_int    <= 1'b0;
            timer_int  <= 1'b0;
        end else begin
            if (reg_re) begin
                reg_rdata <= rd_val;
            end
            ext_int   <= (best_id != '0);
            timer_int <= (mtime >= mtimecmp);

            // A source being claimed this edge counts as in service already.
            pending    <= (pending & ~claim_mask) |
                          (irq_src & ~(in_service | claim_mask));
            in_service <= (in_service | claim_mask) & ~complete_mask;

            if (reg_we) begin
                case (reg_addr)
                    ADDR_ENABLE:    enable    <= reg_wdata[NUM_SRC-1:0];
                    ADDR_THRESHOLD: threshold <= reg_wdata[PRIO_W-1:0];
                    ADDR_MTIMECMP:  mtimecmp  <= reg_wdata;
                    default: begin
                        for (int i = 0; i < NUM_SRC; i++) begin
                            if (prio_hit && (prio_idx == 6'(i))) begin
                                prio[i] <= reg_wdata[PRIO_W-1:0];
                            end
                        end
                    end
                endcase
            end

            // An MTIME write overrides the increment and restarts the prescaler.
            if (reg_we && (reg_addr == ADDR_MTIME)) begin
                mtime     <= reg_wdata;
                prescaler <= '0;
            end else if (tick) begin
                mtime     <= mtime + 32'd1;
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed and randomized checks of irq_ctrl against a
// behavioural model; two instances cover TICK_DIV=4 and TICK_DIV=1.
module tb_irq_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_src;
    logic         reg_re;
    logic         reg_we;
    logic [7:0]   reg_addr;
    logic [31:0]  reg_wdata;
    logic [31:0]  rdata_s, rdata_f;
    logic         ext_s, ext_f, tmr_s, tmr_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_SRC(N), .PRIO_W(3), .TICK_DIV(4)) u_slow (
        .clk(clk), .rst(rst), .irq_src(irq_src), .reg_re(reg_re), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata_s),
        .ext_int(ext_s), .timer_int(tmr_s));

    irq_ctrl #(.NUM_SRC(N), .PRIO_W(3), .TICK_DIV(1)) u_fast (
        .clk(clk), .rst(rst), .irq_src(irq_src), .reg_re(reg_re), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata_f),
        .ext_int(ext_f), .timer_int(tmr_f));

    // Behavioural model state (index 0 = TICK_DIV 4, index 1 = TICK_DIV 1)
    bit          m_en   [1:N];
    bit          m_pend [1:N];
    bit          m_isv  [1:N];
    int unsigned m_prio [1:N];
    int unsigned m_thr;
    logic [31:0] m_mtime [2];
    logic [31:0] m_cmp   [2];
    int unsigned m_ps    [2];
    int unsigned m_div   [2];
    logic [31:0] m_rd    [2];
    logic        m_tmr   [2];
    logic        m_ext;

    function automatic bit eligible(int id);
        return m_pend[id] && m_en[id] && (m_prio[id] > m_thr);
    endfunction

    // Highest eligible priority first, then the lowest ID holding it.
    function automatic int model_best();
        int top = -1;
        for (int id = 1; id <= N; id++)
            if (eligible(id) && int'(m_prio[id]) > top) top = int'(m_prio[id]);
        if (top < 0) return 0;
        for (int id = 1; id <= N; id++)
            if (eligible(id) && int'(m_prio[id]) == top) return id;
        return 0;
    endfunction

    function automatic logic [31:0] model_read(int k, logic [7:0] a);
        logic [31:0] v = '0;
        int ai = int'(a);
        case (ai)
            'h00: for (int id = 1; id <= N; id++) v[id-1] = m_en[id];
            'h04: for (int id = 1; id <= N; id++) v[id-1] = m_pend[id];
            'h08: v = m_thr;
            'h0C: v = model_best();
            'h10: v = m_mtime[k];
            'h14: v = m_cmp[k];
            default: if (ai >= 'h40 && ai % 4 == 0 && (ai - 'h40) / 4 < N)
                         v = m_prio[(ai - 'h40) / 4 + 1];
        endcase
        return v;
    endfunction

    task automatic model_reset();
        for (int id = 1; id <= N; id++) begin
            m_en[id] = 0; m_pend[id] = 0; m_isv[id] = 0; m_prio[id] = 0;
        end
        m_thr = 0;
        m_ext = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_mtime[k] = '0; m_cmp[k] = 32'hFFFF_FFFF; m_ps[k] = 0;
            m_rd[k] = '0; m_tmr[k] = 1'b0;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the driven inputs, then compare.
    task automatic step();
        int          bid;
        bit          claim;
        bit          rd_chk;
        int          wv;
        int          ai;
        logic [31:0] r [2];
        logic        t [2];
        rd_chk = reg_re || rst;
        if (rst) begin
            model_reset();
        end else begin
            bid  = model_best();
            r[0] = model_read(0, reg_addr);
            r[1] = model_read(1, reg_addr);
            for (int k = 0; k < 2; k++) t[k] = (m_mtime[k] >= m_cmp[k]);
            claim = reg_re && reg_addr == 8'h0C && bid != 0;
            for (int id = 1; id <= N; id++)
                if (irq_src[id-1] && !m_isv[id] && !(claim && id == bid)) m_pend[id] = 1;
            if (claim) begin
                m_pend[bid] = 0;
                m_isv[bid]  = 1;
            end
            ai = int'(reg_addr);
            if (reg_we) begin
                wv = int'(reg_wdata[7:0]);
                case (ai)
                    'h00: for (int id = 1; id <= N; id++) m_en[id] = reg_wdata[id-1];
                    'h08: m_thr = reg_wdata & 32'h7;
                    'h0C: if (reg_wdata >= 1 && reg_wdata <= N) m_isv[wv] = 0;
                    'h14: begin m_cmp[0] = reg_wdata; m_cmp[1] = reg_wdata; end
                    default: if (ai >= 'h40 && ai % 4 == 0 && (ai - 'h40) / 4 < N)
                                 m_prio[(ai - 'h40) / 4 + 1] = reg_wdata & 32'h7;
                endcase
            end
            for (int k = 0; k < 2; k++) begin
                if (reg_we && ai == 'h10) begin
                    m_mtime[k] = reg_wdata; m_ps[k] = 0;
                end else if (m_ps[k] == m_div[k] - 1) begin
                    m_mtime[k] = m_mtime[k] + 32'd1; m_ps[k] = 0;
                end else begin
                    m_ps[k]++;
                end
                if (reg_re) m_rd[k] = r[k];
                m_tmr[k] = t[k];
            end
            m_ext = (bid != 0);
        end
        @(posedge clk);
        #1;
        chk("model_ext_slow", 32'(ext_s), 32'(m_ext));
        chk("model_ext_fast", 32'(ext_f), 32'(m_ext));
        chk("model_tmr_slow", 32'(tmr_s), 32'(m_tmr[0]));
        chk("model_tmr_fast", 32'(tmr_f), 32'(m_tmr[1]));
        if (rd_chk) begin
            chk("model_rdata_slow", rdata_s, m_rd[0]);
            chk("model_rdata_fast", rdata_f, m_rd[1]);
        end
    endtask

    task automatic idle();
        reg_re = 1'b0; reg_we = 1'b0;
        step();
    endtask

    task automatic rd(logic [7:0] a);
        reg_re = 1'b1; reg_we = 1'b0; reg_addr = a;
        step();
        reg_re = 1'b0;
    endtask

    task automatic wr(logic [7:0] a, logic [31:0] d);
        reg_re = 1'b0; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        step();
        reg_we = 1'b0;
    endtask

    initial begin
        logic [7:0] raddr [15];
        int op;
        raddr = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h40,
                  8'h44, 8'h48, 8'h4C, 8'h50, 8'h54, 8'h58, 8'h5C};
        m_div[0] = 4;
        m_div[1] = 1;
        rst = 1'b1; irq_src = '0; reg_re = 1'b0; reg_we = 1'b0;
        reg_addr = '0; reg_wdata = '0;
        step();
        step();
        chk("rst_ext", 32'(ext_s), 32'd0);
        chk("rst_tmr", 32'(tmr_s), 32'd0);
        chk("rst_rdata", rdata_s, 32'd0);
        rst = 1'b0;

        // Reset values of every register
        for (int i = 0; i < 15; i++) rd(raddr[i]);
        rd(8'h14);
        chk("rst_mtimecmp", rdata_s, 32'hFFFF_FFFF);
        rd(8'h00);
        chk("rst_enable", rdata_s, 32'd0);

        // Tie between IDs 3 and 6 at priority 5
        wr(8'h48, 32'd5);
        wr(8'h54, 32'd5);
        wr(8'h00, 32'hFF);
        wr(8'h08, 32'd2);
        irq_src = 8'b0010_0100;
        idle();
        chk("ext_lat1", 32'(ext_s), 32'd0);
        idle();
        chk("ext_lat2", 32'(ext_s), 32'd1);
        rd(8'h0C);
        chk("claim_first", rdata_s, 32'd3);
        rd(8'h0C);
        chk("claim_second", rdata_s, 32'd6);
        rd(8'h0C);
        chk("claim_third", rdata_s, 32'd0);
        chk("ext_after_claims", 32'(ext_s), 32'd0);
        rd(8'h04);
        chk("pend_in_service", rdata_s, 32'd0);

        // Complete 3 with the line still high
        wr(8'h0C, 32'd3);
        rd(8'h04);
        chk("pend_after_cmp1", rdata_s, 32'd0);
        chk("ext_after_cmp1", 32'(ext_s), 32'd0);
        rd(8'h04);
        chk("pend_after_cmp2", rdata_s, 32'h04);
        chk("ext_after_cmp2", 32'(ext_s), 32'd1);

        // Completes of IDs that are not in service are ignored
        wr(8'h0C, 32'd0);
        wr(8'h0C, 32'd9);
        wr(8'h0C, 32'd4);
        rd(8'h04);
        chk("pend_bad_cmp", rdata_s, 32'h04);
        chk("ext_bad_cmp", 32'(ext_s), 32'd1);
        rd(8'h0C);
        chk("claim_after_bad_cmp", rdata_s, 32'd3);

        // Claim and complete of ID 3 in the same cycle
        wr(8'h0C, 32'd3);
        idle();
        reg_re = 1'b1; reg_we = 1'b1; reg_addr = 8'h0C; reg_wdata = 32'd3;
        step();
        chk("claim_cmp_same", rdata_s, 32'd3);
        rd(8'h04);
        chk("pend_same_1", rdata_s, 32'd0);
        rd(8'h04);
        chk("pend_same_2", rdata_s, 32'h04);
        irq_src = '0;

        // Timer with TICK_DIV=4
        wr(8'h14, 32'd3);
        wr(8'h10, 32'd0);
        for (int i = 0; i < 12; i++) idle();
        chk("tmr_before", 32'(tmr_s), 32'd0);
        idle();
        chk("tmr_assert", 32'(tmr_s), 32'd1);
        wr(8'h14, 32'hFFFF_FFFF);
        idle();
        chk("tmr_deassert", 32'(tmr_s), 32'd0);

        // Wrap-around and write/increment collision
        wr(8'h10, 32'hFFFF_FFFF);
        idle();
        rd(8'h10);
        chk("wrap_fast", rdata_f, 32'd0);
        chk("wrap_slow", rdata_s, 32'hFFFF_FFFF);
        wr(8'h10, 32'h1234);
        rd(8'h10);
        chk("write_wins", rdata_f, 32'h1234);
        reg_re = 1'b1; reg_we = 1'b1; reg_addr = 8'h10; reg_wdata = 32'h55;
        step();
        chk("rw_pre_value", rdata_f, 32'h1235);
        rd(8'h10);
        chk("rw_post_value", rdata_f, 32'h55);

        // Reset with a claim in flight
        irq_src = 8'h01;
        wr(8'h00, 32'h01);
        wr(8'h40, 32'd7);
        idle();
        idle();
        chk("pre_rst_ext", 32'(ext_s), 32'd1);
        rst = 1'b1; reg_re = 1'b1; reg_addr = 8'h0C;
        step();
        chk("rst_claim_rdata", rdata_s, 32'd0);
        chk("rst_claim_ext", 32'(ext_s), 32'd0);
        rst = 1'b0; reg_re = 1'b0;
        rd(8'h04);
        chk("rst_claim_pend", rdata_s, 32'd0);
        irq_src = '0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            op = $urandom_range(0, 9);
            reg_re = (op <= 3) || (op == 7);
            reg_we = (op >= 4) && (op <= 7);
            reg_addr = raddr[$urandom_range(0, 14)];
            if ($urandom_range(0, 3) == 0) reg_addr = 8'h0C;
            if (reg_addr == 8'h0C) reg_wdata = $urandom_range(0, 10);
            else if (reg_addr == 8'h10 || reg_addr == 8'h14)
                reg_wdata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
            else reg_wdata = $urandom;
            step();
        end
        rst = 1'b0; reg_re = 1'b0; reg_we = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
